// File: rtl/ram_16x1k_sp_master.sv
// ============================================================================
// Module   : ram_16x1k_sp_master
// Brief    : Valid/ready front end for a 16x1K byte-write single-port RAM,
//            with a 2-entry read response buffer and a bulk-clear engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_16x1k_sp_master #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_value,
    output logic          clr_busy,
    output logic          ena,
    output logic [1:0]    wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dina,
    input  logic [DW-1:0] douta
);

    localparam logic [AW-1:0] c_LAST_ADDR = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_clr_cnt;
    logic [DW-1:0] r_clr_val;
    logic          r_rd_pend;
    logic [DW-1:0] r_fifo [0:1];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_addr_hold;
    logic [DW-1:0] r_din_hold;

    logic w_accept;
    logic w_push;
    logic w_pop;

    // Ready counts the in-flight read so a full buffer can never overflow.
    assign clr_busy  = (r_state == S_FILL);
    assign req_ready = !clr_busy && (({1'b0, r_cnt} + {2'b00, r_rd_pend}) < 3'd2);
    assign w_accept  = req_valid && req_ready;
    assign w_push    = r_rd_pend;
    assign w_pop     = rsp_valid && rsp_ready;

    assign rsp_valid = (r_cnt != 2'd0);
    assign rsp_rdata = r_fifo[r_rptr];

    // Accept and FILL are mutually exclusive since ready is low while busy.
    assign ena   = w_accept || clr_busy;
    assign wea   = w_accept ? req_we    : (clr_busy ? 2'b11     : 2'b00);
    assign addra = w_accept ? req_addr  : (clr_busy ? r_clr_cnt : r_addr_hold);
    assign dina  = w_accept ? req_wdata : (clr_busy ? r_clr_val : r_din_hold);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
            r_clr_val <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_state   <= S_FILL;
                        r_clr_val <= clr_value;
                        r_clr_cnt <= '0;
                    end
                end
                S_FILL: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == c_LAST_ADDR) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_hold <= '0;
            r_din_hold  <= '0;
        end else if (ena) begin
            r_addr_hold <= addra;
            r_din_hold  <= dina;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt     <= 2'd0;
        end else begin
            r_rd_pend <= w_accept && (req_we == 2'b00);
            if (w_push) begin
                r_fifo[r_wptr] <= douta;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_16x1k_sp_master.sv
// ============================================================================
// Module   : tb_ram_16x1k_sp_master
// Brief    : Scoreboard bench for ram_16x1k_sp_master with a behavioural RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_16x1k_sp_master;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clka = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_we = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_value = '0;
    logic          clr_busy;
    logic          ena;
    logic [1:0]    wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic [DW-1:0] douta = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mem [0:1023];

    always #5 clka = ~clka;

    ram_16x1k_sp_master #(.AW(AW), .DW(DW)) dut (
        .clka(clka), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
    );

    // Registered, write-first, byte-enabled RAM
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    end
    always @(posedge clka) begin
        if (ena) begin
            if (wea[0]) mem[addra][7:0]  <= dina[7:0];
            if (wea[1]) mem[addra][15:8] <= dina[15:8];
            douta <= {wea[1] ? dina[15:8] : mem[addra][15:8],
                      wea[0] ? dina[7:0]  : mem[addra][7:0]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic issue(input logic [1:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: got ready=0 expected ready=1 addr %h", addr);
        end else if (we == 2'b00) begin
            exp_q.push_back(exp_rd);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a response is consumed at the next rising edge.
    always @(negedge clka) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got %h expected none", rsp_rdata);
            end else begin
                check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && dut.r_cnt > 2'd2) begin
            miscompares++;
            $display("FAIL fifo_overflow: got count %0d expected at most 2", dut.r_cnt);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sweep_err;
        int busy_cycles;

        repeat (3) @(posedge clka);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_clr_busy",  32'(clr_busy),  32'd0);
        check("rst_ena",       32'(ena),       32'd0);
        check("rst_wea",       32'(wea),       32'd0);
        check("rst_addra",     32'(addra),     32'd0);
        check("rst_dina",      32'(dina),      32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clka);
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Full write then read-back with latency check
        req_valid = 1'b1; req_we = 2'b11; req_addr = 10'h005; req_wdata = 16'h3A5C;
        #0;
        check("drv_ena",   32'(ena),   32'd1);
        check("drv_wea",   32'(wea),   32'd3);
        check("drv_addra", 32'(addra), 32'h005);
        check("drv_dina",  32'(dina),  32'h3A5C);
        issue(2'b11, 10'h005, 16'h3A5C, 16'h0);
        issue(2'b00, 10'h005, 16'h0, 16'h3A5C);
        check("lat_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        check("lat_valid", 32'(rsp_valid), 32'd1);
        check("lat_rdata", 32'(rsp_rdata), 32'h3A5C);
        drain();
        check("hold_ena",   32'(ena),   32'd0);
        check("hold_wea",   32'(wea),   32'd0);
        check("hold_addra", 32'(addra), 32'h005);

        // Byte-lane merge
        issue(2'b11, 10'h010, 16'hFFFF, 16'h0);
        issue(2'b01, 10'h010, 16'h1234, 16'h0);
        issue(2'b10, 10'h010, 16'hAB00, 16'h0);
        issue(2'b00, 10'h010, 16'h0, 16'hAB34);
        drain();

        // Backpressure: two reads fit, third waits for the first pop
        issue(2'b11, 10'h3FF, 16'h1111, 16'h0);
        issue(2'b11, 10'h000, 16'h2222, 16'h0);
        issue(2'b11, 10'h001, 16'h3333, 16'h0);
        rsp_ready = 1'b0;
        issue(2'b00, 10'h3FF, 16'h0, 16'h1111);
        issue(2'b00, 10'h000, 16'h0, 16'h2222);
        req_valid = 1'b1; req_we = 2'b00; req_addr = 10'h001;
        check("bp_ready0", 32'(req_ready), 32'd0);
        repeat (3) tick();
        check("bp_ready3", 32'(req_ready), 32'd0);
        check("bp_valid",  32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        issue(2'b00, 10'h001, 16'h0, 16'h3333);
        drain();

        // Clear with a read issued on the start cycle
        clr_start = 1'b1; clr_value = 16'hBEEF;
        issue(2'b00, 10'h005, 16'h0, 16'h3A5C);
        clr_start = 1'b0; clr_value = 16'h0000;
        sweep_err = 0;
        busy_cycles = 0;
        for (int i = 0; i < 1024; i++) begin
            if (clr_busy) busy_cycles++;
            if (addra !== 10'(i) || wea !== 2'b11 || dina !== 16'hBEEF ||
                ena !== 1'b1 || req_ready !== 1'b0) sweep_err++;
            tick();
        end
        check("clr_busy_cycles", 32'(busy_cycles), 32'd1024);
        check("clr_sweep_err",   32'(sweep_err),   32'd0);
        check("clr_done",        32'(clr_busy),    32'd0);
        issue(2'b00, 10'h000, 16'h0, 16'hBEEF);
        issue(2'b00, 10'h3FF, 16'h0, 16'hBEEF);
        drain();

        // Reset in the middle of a clear with a buffered response
        issue(2'b11, 10'h000, 16'h0000, 16'h0);
        issue(2'b11, 10'h3FF, 16'h5555, 16'h0);
        drain();
        rsp_ready = 1'b0;
        clr_start = 1'b1; clr_value = 16'hBEEF;
        issue(2'b00, 10'h3FF, 16'h0, 16'h5555);
        clr_start = 1'b0;
        repeat (500) tick();
        check("mid_busy", 32'(clr_busy), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_clr_busy",  32'(clr_busy),  32'd0);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_ena",       32'(ena),       32'd0);
        @(negedge clka);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        issue(2'b00, 10'h000, 16'h0, 16'hBEEF);
        issue(2'b00, 10'h3FF, 16'h0, 16'h5555);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
